// File: rtl/search_scheduler_pkg.sv
// search_pkg: frame geometry, strip shape, SAD width and the scheduler state type.
// Shared by the scheduler, its interface and the strip position counter.
package search_pkg;
  localparam int FRAME_W  = 64;
  localparam int WIN      = 4;
  localparam int L        = FRAME_W - WIN;
  localparam int STRIP_C  = 4;
  localparam int STRIP_R  = 8;
  localparam int N_CAND   = STRIP_C * STRIP_R;
  localparam int N_STRIPS = (FRAME_W / STRIP_C) * (FRAME_W / STRIP_R);
  localparam int SAD_W    = 13;
  localparam int IDX_W    = 5;
  localparam int POS_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_REQ,
    S_UPDATE,
    S_DONE
  } state_e;
endpackage

// File: rtl/search_scheduler_if.sv
// search_scheduler_if: host start/status plus memory-index and SAD comparator handshake.
// master = scheduler side, slave = host / datapath side.
interface search_scheduler_if
  import search_pkg::*;
#(
  parameter int SW = search_pkg::SAD_W
);
  logic              start;
  logic              busy;
  logic              done;
  logic [15:0]       mem_index;
  logic [N_CAND-1:0] cand_mask;
  logic              sad_req;
  logic              sad_valid;
  logic [SW-1:0]     sad_min;
  logic [IDX_W-1:0]  sad_idx;
  logic [SW-1:0]     best_sad;
  logic [POS_W-1:0]  best_x;
  logic [POS_W-1:0]  best_y;
  logic              err;

  modport master (
    input  start, sad_valid, sad_min, sad_idx,
    output busy, done, mem_index, cand_mask, sad_req, best_sad, best_x, best_y, err
  );

  modport slave (
    output start, sad_valid, sad_min, sad_idx,
    input  busy, done, mem_index, cand_mask, sad_req, best_sad, best_x, best_y, err
  );
endinterface

// File: rtl/search_scheduler_strip_pos_counter.sv
// strip_pos_counter: raster x/y strip origin; mask and memory index are derived from the
// position being entered this edge so the scheduler can register them on ISSUE entry.
module strip_pos_counter
  import search_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst,
  input  logic              clear_i,
  input  logic              advance_i,
  output logic [POS_W-1:0]  x_o,
  output logic [POS_W-1:0]  y_o,
  output logic              last_strip_o,
  output logic [N_CAND-1:0] nxt_mask_o,
  output logic [15:0]       nxt_index_o
);
  localparam logic [POS_W-1:0] X_LAST = POS_W'(FRAME_W - STRIP_C);
  localparam logic [POS_W-1:0] Y_LAST = POS_W'(FRAME_W - STRIP_R);

  logic [POS_W-1:0] x_q, y_q, x_d, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear_i) begin
      x_d = '0;
      y_d = '0;
    end else if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + POS_W'(STRIP_R);
      end else begin
        x_d = x_q + POS_W'(STRIP_C);
      end
    end
  end

  // Candidates whose window would run past the frame edge are masked off.
  always_comb begin
    nxt_mask_o = '0;
    for (int r = 0; r < STRIP_R; r++) begin
      for (int c = 0; c < STRIP_C; c++) begin
        nxt_mask_o[r*STRIP_C + c] = (int'(x_d) + c <= L) && (int'(y_d) + r <= L);
      end
    end
  end

  assign nxt_index_o  = 16'(y_d) * 16'(FRAME_W) + 16'(x_d);
  assign last_strip_o = (x_q == X_LAST) && (y_q == Y_LAST);
  assign x_o          = x_q;
  assign y_o          = y_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
endmodule

// File: rtl/search_scheduler.sv
// search_scheduler: full-search block-matching sequencer; SEARCH_EARLY_EXIT_EN ends on a zero SAD.
// Per strip MEM_WAIT+2 cycles plus comparator latency; REQ waits indefinitely for sad_valid.
module search_scheduler
  import search_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input logic                Clk,
  input logic                Rst,
  search_scheduler_if.master bus
);
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

  state_e              state_q;
  logic [3:0]          wait_q;
  logic                busy_q, done_q, sad_req_q, err_q;
  logic [15:0]         mem_index_q;
  logic [N_CAND-1:0]   cand_mask_q;
  logic [SAD_W-1:0]    best_sad_q, sad_min_q;
  logic [POS_W-1:0]    best_x_q, best_y_q;
  logic [IDX_W-1:0]    sad_idx_q;

  logic [POS_W-1:0]    pos_x, pos_y, cand_c, cand_r;
  logic [N_CAND-1:0]   nxt_mask;
  logic [15:0]         nxt_index;
  logic                last_strip, clear, advance, hit, better, finish;

  assign clear   = (state_q == S_IDLE) && bus.start;
  assign advance = (state_q == S_UPDATE) && !finish;
  assign hit     = cand_mask_q[sad_idx_q];
  assign better  = hit && (sad_min_q < best_sad_q);
  assign cand_c  = POS_W'(sad_idx_q % IDX_W'(STRIP_C));
  assign cand_r  = POS_W'(sad_idx_q / IDX_W'(STRIP_C));

`ifdef SEARCH_EARLY_EXIT_EN
  assign finish = last_strip || (better && (sad_min_q == '0));
`else
  assign finish = last_strip;
`endif

  strip_pos_counter u_pos (
    .Clk          (Clk),
    .Rst          (Rst),
    .clear_i      (clear),
    .advance_i    (advance),
    .x_o          (pos_x),
    .y_o          (pos_y),
    .last_strip_o (last_strip),
    .nxt_mask_o   (nxt_mask),
    .nxt_index_o  (nxt_index)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sad_req_q   <= 1'b0;
      err_q       <= 1'b0;
      mem_index_q <= '0;
      cand_mask_q <= '0;
      best_sad_q  <= '1;
      best_x_q    <= '0;
      best_y_q    <= '0;
      sad_min_q   <= '0;
      sad_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q     <= S_ISSUE;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            best_sad_q  <= '1;
            best_x_q    <= '0;
            best_y_q    <= '0;
            wait_q      <= WAIT_INIT;
            mem_index_q <= nxt_index;
            cand_mask_q <= nxt_mask;
          end
        end
        S_ISSUE: begin
          if (wait_q == '0) begin
            state_q   <= S_REQ;
            sad_req_q <= 1'b1;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        S_REQ: begin
          if (bus.sad_valid) begin
            sad_min_q <= bus.sad_min;
            sad_idx_q <= bus.sad_idx;
            sad_req_q <= 1'b0;
            state_q   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (!hit) begin
            err_q <= 1'b1;
          end else if (better) begin
            best_sad_q <= sad_min_q;
            best_x_q   <= pos_x + cand_c;
            best_y_q   <= pos_y + cand_r;
          end
          if (finish) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q     <= S_ISSUE;
            wait_q      <= WAIT_INIT;
            mem_index_q <= nxt_index;
            cand_mask_q <= nxt_mask;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sad_req   = sad_req_q;
  assign bus.err       = err_q;
  assign bus.mem_index = mem_index_q;
  assign bus.cand_mask = cand_mask_q;
  assign bus.best_sad  = best_sad_q;
  assign bus.best_x    = best_x_q;
  assign bus.best_y    = best_y_q;
endmodule

// File: doc/search_scheduler.md
# search_scheduler

Sequences a full-search block-matching pass over a 64×64 frame held in data memory. Each step issues a base index to the memory/window datapath, which exposes a 7×11 pixel strip, and then waits for the downstream SAD comparator to return the minimum SAD for the 32 candidate positions in that strip. The block tracks the global best match and reports its position. It is the top-level controller between `start` from the testbench or host and the data memory plus SAD tree.

## Interface
- `FRAME_W`, default 64: frame width and height in pixels.
- `WIN`, default 4: window edge length in pixels.
- `STRIP_C`, default 4: candidate columns per strip.
- `STRIP_R`, default 8: candidate rows per strip.
- `MEM_WAIT`, default 1: cycles `mem_index` is held before `sad_req` asserts (range 1–15).
- `SAD_W`, default 13: SAD width (16 × 511 max).
- `Clk`  in  1: sole clock, rising edge.
- `Rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: begin a search; sampled only in IDLE.
- `busy`  out  1: high from the cycle after `start` until `done`.
- `done`  out  1: one-cycle pulse when the search completes.
- `mem_index`  out  16: base index i = y·FRAME_W + x for the data memory.
- `cand_mask`  out  32: valid candidates in the current strip; bit k = r·STRIP_C + c.
- `sad_req`  out  1: strip data is stable and a SAD result is requested.
- `sad_valid`  in  1: comparator result is valid; accepted only while `sad_req` is high.
- `sad_min`  in  SAD_W: minimum SAD within the strip.
- `sad_idx`  in  5: candidate index k of `sad_min`.
- `best_sad`  out  SAD_W: global minimum SAD.
- `best_x`, `best_y`  out  6 each: position of the best match.
- `err`  out  1: sticky; a response pointed at a masked candidate.

## Operation
- States are IDLE, ISSUE, REQ, UPDATE and DONE.
- IDLE → ISSUE on `start`. This cycle sets x = y = 0, `best_sad` = all ones, and clears `err`.
- ISSUE: `mem_index` is driven from the current x and y. The state lasts MEM_WAIT cycles, then moves to REQ.
- REQ: `sad_req` = 1 and the block waits indefinitely for `sad_valid`.
  - On `sad_valid`, it latches `sad_min`/`sad_idx` and moves to UPDATE.
- UPDATE: decodes r = idx / STRIP_C and c = idx % STRIP_C.
  - If mask bit idx is clear, it sets `err` and makes no update.
  - Otherwise, if `sad_min` < `best_sad` (strict), it sets `best_sad` = `sad_min`, `best_x` = x + c and `best_y` = y + r.
  - Ties keep the earlier candidate in raster strip order.
  - Then it advances the strip, or goes to DONE when this was the last strip.
- Strip order is x from 0 in steps of STRIP_C up to 60, then x wraps to 0 and y advances by STRIP_R up to 56. This gives 16 × 8 = 128 strips.
- Last valid candidate coordinate is L = FRAME_W − WIN = 60.
- Mask bit k is set iff x + c ≤ L and y + r ≤ L.
- DONE: `done` = 1 for one cycle, then the block returns to IDLE. Results hold until the next `start`.
- `start` while not in IDLE is ignored.
- `sad_valid` outside REQ is ignored.

## Timing
- Reset values:
  - state IDLE
  - `busy`, `done`, `sad_req`, `err` = 0
  - `mem_index` = 0
  - `cand_mask` = 0
  - `best_sad` = all ones
  - `best_x` = `best_y` = 0
- `Rst` in any state returns to IDLE on the next edge. Any in-flight strip is abandoned and no `done` is produced.
- `mem_index` and `cand_mask` are registered. Both change only on entry to ISSUE and stay stable through REQ.
- Per-strip cost is MEM_WAIT + 2 + comparator latency cycles. With MEM_WAIT = 1 and a same-cycle `sad_valid`, each strip takes 3 cycles. The full search then takes 1 + 128·3 = 385 cycles from `start` to `done`.
- `best_*` outputs update on the edge that leaves UPDATE.

## Configuration
- `SEARCH_EARLY_EXIT_EN`:
  - Defined: if `best_sad` becomes 0 in UPDATE, go to DONE immediately, skipping the remaining strips.
  - Undefined: all 128 strips are always visited regardless of SAD value.

## Structure
- Package `search_pkg` holds:
  - the state enum
  - FRAME_W, WIN, L = 60, STRIP_C, STRIP_R
  - the strip count of 128
  - the SAD_W localparam
- Sub-module `strip_pos_counter` holds x/y, advance/clear inputs, the `last_strip` flag, the combinational `cand_mask` and `mem_index` generation.

## Test plan
- All responses return `sad_min` = 100, `sad_idx` = 0, except strip (x=8, y=16), which returns 5 with idx 6 → `best_sad` = 5, `best_x` = 10, `best_y` = 17, exactly one `done`, 128 `sad_req` handshakes.
- Ties: strips (0,0) and (4,0) both return 7 with idx 0 → best = (0,0).
- Masks and indices:
  - strip (60,0) → `cand_mask` = 0x11111111
  - strip (0,56) → `cand_mask` = 0x000FFFFF
  - strip (60,56) → `cand_mask` = 0x00011111
  - strip (4,8) → `mem_index` = 516
- At strip (60,56), respond with idx 1 → `err` = 1 and the best result is unchanged.
- Assert `Rst` during REQ of strip 10 → next cycle `busy` = 0, `sad_req` = 0, `best_sad` = 0x1FFF, no `done`. A new `start` then completes normally.
- Strip 3 returns 0:
  - With `SEARCH_EARLY_EXIT_EN` defined, `done` arrives after 4 handshakes.
  - Without it, `done` arrives after 128 handshakes with the same best.
